// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings, default width
// and a helper that extracts one channel's duty from the packed duty bus.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int CNT_W_DEF = 21;
    localparam int MAX_W     = 32;
    localparam int MAX_CH    = 16;
    localparam int MAX_BUS   = MAX_W * MAX_CH;

    // The caller pads its bus to MAX_BUS bits and casts the result back to its own width.
    function automatic logic [MAX_W-1:0] duty_slice(input logic [MAX_BUS-1:0] bus,
                                                     input int w, input int i);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - w);
        return MAX_W'(bus >> (i * w)) & mask;
    endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: active duty register, compare against the shared counter,
// polarity inversion and the registered output pin.
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             enable,
    input  logic [CNT_W-1:0] cnt,
    input  logic             upd,
    input  logic [CNT_W-1:0] duty_next,
    input  logic             polarity,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_act;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            duty_act <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (upd) duty_act <= duty_next;
            // Disabled channels rest at the inactive level, which is the polarity bit.
            pwm_out <= (enable && (cnt < duty_act)) ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared edge/center-aligned period counter, shadowed
// period/duty/mode registers swapped at the period boundary, and a boundary tick.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_p,
    input  logic                    enable,
    input  logic                    mode_in,
    input  logic [CNT_W-1:0]        period_in,
    input  logic [CH_NUM*CNT_W-1:0] duty_in,
    input  logic [CH_NUM-1:0]       polarity,
    input  logic                    load,
    output logic [CH_NUM-1:0]       pwm_out,
    output logic                    period_tick,
    output logic                    load_pending
);

    logic [CNT_W-1:0]        cnt;
    logic                    dir_down;
    logic                    mode_act;
    logic [CNT_W-1:0]        period_act;
    logic                    mode_pend;
    logic [CNT_W-1:0]        period_pend;
    logic [CH_NUM*CNT_W-1:0] duty_pend;

    logic                    bnd;
    logic                    swap_point;
    logic                    upd;
    logic                    mode_src;
    logic [CNT_W-1:0]        period_src;
    logic [CH_NUM*CNT_W-1:0] duty_src;
    logic [MAX_BUS-1:0]      duty_pad;

    // Center mode boundary is the 1->0 step; with P=1 that step follows the peak directly.
    always_comb begin
        bnd = 1'b0;
        if (period_act == '0)
            bnd = 1'b1;
        else if (mode_act == MODE_EDGE)
            bnd = (cnt == period_act);
        else
            bnd = (cnt == CNT_W'(1)) && (dir_down || period_act == CNT_W'(1));
    end

    // While disabled every clock behaves as a swap point, so loads apply at once.
    assign swap_point = !enable || bnd;
    assign upd        = swap_point && (load || load_pending);
    assign mode_src   = load ? mode_in   : mode_pend;
    assign period_src = load ? period_in : period_pend;
    assign duty_src   = load ? duty_in   : duty_pend;
    assign duty_pad   = MAX_BUS'(duty_src);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            mode_act     <= MODE_EDGE;
            period_act   <= '0;
            mode_pend    <= MODE_EDGE;
            period_pend  <= '0;
            duty_pend    <= '0;
            load_pending <= 1'b0;
            period_tick  <= 1'b0;
        end else begin
            if (load) begin
                mode_pend   <= mode_in;
                period_pend <= period_in;
                duty_pend   <= duty_in;
            end
            if (upd) begin
                mode_act   <= mode_src;
                period_act <= period_src;
            end
            if (swap_point)
                load_pending <= 1'b0;
            else if (load)
                load_pending <= 1'b1;
            period_tick <= enable && bnd;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (swap_point) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (mode_act == MODE_EDGE) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!dir_down) begin
            if (cnt == period_act) begin
                cnt      <= cnt - CNT_W'(1);
                dir_down <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [CNT_W-1:0] duty_ch;
        assign duty_ch = CNT_W'(duty_slice(duty_pad, CNT_W, i));

        pwm_cmp_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset_p   (reset_p),
            .enable    (enable),
            .cnt       (cnt),
            .upd       (upd),
            .duty_next (duty_ch),
            .polarity  (polarity[i]),
            .pwm_out   (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: directed scenarios plus random segments,
// each cycle compared against a phase-index reference model.
module tb_pwm_multi_ch;

    localparam int CH = 4;
    localparam int W  = 21;

    logic              clk = 1'b0;
    logic              reset_p;
    logic              enable;
    logic              mode_in;
    logic [W-1:0]      period_in;
    logic [CH*W-1:0]   duty_in;
    logic [CH-1:0]     polarity;
    logic              load;
    logic [CH-1:0]     pwm_out;
    logic              period_tick;
    logic              load_pending;

    pwm_multi_ch #(.CH_NUM(CH), .CNT_W(W)) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .enable       (enable),
        .mode_in      (mode_in),
        .period_in    (period_in),
        .duty_in      (duty_in),
        .polarity     (polarity),
        .load         (load),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick),
        .load_pending (load_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: position m_k inside the current cycle, counter value derived arithmetically.
    int unsigned m_k, m_P, m_pP;
    logic        m_mode, m_pmode, m_pend;
    int unsigned m_duty[CH];
    int unsigned m_pduty[CH];
    logic [CH-1:0] exp_out;
    logic          exp_tick;

    int hi[CH];
    int ticks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_P = 0; m_pP = 0;
        m_mode = 1'b0; m_pmode = 1'b0; m_pend = 1'b0;
        exp_out = '0; exp_tick = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_pduty[i] = 0;
        end
    endtask

    task automatic model_update();
        int unsigned len, c;
        logic bnd;
        len = m_mode ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
        c   = (!m_mode || m_k <= m_P) ? m_k : 2 * m_P - m_k;
        bnd = enable && (m_k == len - 1);
        for (int i = 0; i < CH; i++)
            exp_out[i] = (enable && (c < m_duty[i])) ^ polarity[i];
        exp_tick = bnd;
        if (!enable || bnd) begin
            if (load) begin
                m_mode = mode_in; m_P = period_in;
                for (int i = 0; i < CH; i++) m_duty[i] = duty_in[i*W +: W];
            end else if (m_pend) begin
                m_mode = m_pmode; m_P = m_pP;
                for (int i = 0; i < CH; i++) m_duty[i] = m_pduty[i];
            end
            m_pend = 1'b0;
            m_k = 0;
        end else begin
            if (load) begin
                m_pmode = mode_in; m_pP = period_in;
                for (int i = 0; i < CH; i++) m_pduty[i] = duty_in[i*W +: W];
                m_pend = 1'b1;
            end
            m_k++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), 32'(exp_out));
        chk("period_tick", 32'(period_tick), 32'(exp_tick));
        chk("load_pending", 32'(load_pending), 32'(m_pend));
        for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
        ticks += int'(period_tick);
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        ticks = 0;
    endtask

    task automatic do_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty_in[0*W +: W] = W'(d0);
        duty_in[1*W +: W] = W'(d1);
        duty_in[2*W +: W] = W'(d2);
        duty_in[3*W +: W] = W'(d3);
    endtask

    task automatic sync_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!period_tick && n < 100);
        chk("sync_tick", 32'(period_tick), 32'd1);
    endtask

    initial begin
        int n;
        reset_p = 1'b1; enable = 1'b0; mode_in = 1'b0; period_in = '0;
        duty_in = '0; polarity = '0; load = 1'b0;
        model_reset();
        clr();
        repeat (2) @(negedge clk);
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);
        chk("reset_lp", 32'(load_pending), 32'd0);
        reset_p = 1'b0;

        // Edge basic: P=9, duties 0/3/5/12
        period_in = 9; mode_in = 1'b0; set_duty(0, 3, 5, 12);
        do_load();
        chk("edge_load_disabled_lp", 32'(load_pending), 32'd0);
        enable = 1'b1;
        run(10);
        clr();
        run(20);
        chk("edge_hi0", 32'(hi[0]), 32'd0);
        chk("edge_hi1", 32'(hi[1]), 32'd6);
        chk("edge_hi2", 32'(hi[2]), 32'd10);
        chk("edge_hi3", 32'(hi[3]), 32'd20);
        chk("edge_ticks", 32'(ticks), 32'd2);

        // Center mode: P=8, 16-clock cycle
        period_in = 8; mode_in = 1'b1; set_duty(4, 0, 9, 1);
        do_load();
        run(20);
        clr();
        run(32);
        chk("ctr_hi0", 32'(hi[0]), 32'd14);
        chk("ctr_hi1", 32'(hi[1]), 32'd0);
        chk("ctr_hi2", 32'(hi[2]), 32'd32);
        chk("ctr_hi3", 32'(hi[3]), 32'd2);
        chk("ctr_ticks", 32'(ticks), 32'd2);

        // Shadow timing: load duty 7 at cnt=4 of a P=9 edge cycle with duty 3
        period_in = 9; mode_in = 1'b0; set_duty(3, 3, 3, 3);
        do_load();
        run(30);
        sync_tick();
        clr();
        run(4);
        set_duty(7, 3, 3, 3);
        do_load();
        chk("shadow_lp_set", 32'(load_pending), 32'd1);
        run(5);
        chk("shadow_old_hi0", 32'(hi[0]), 32'd3);
        chk("shadow_lp_clr", 32'(load_pending), 32'd0);
        clr();
        run(10);
        chk("shadow_new_hi0", 32'(hi[0]), 32'd7);

        // Bypass: load in the boundary cycle (cnt=9)
        run(9);
        set_duty(2, 3, 3, 3);
        do_load();
        chk("bypass_lp", 32'(load_pending), 32'd0);
        clr();
        run(10);
        chk("bypass_hi0", 32'(hi[0]), 32'd2);

        // Double load: last one wins
        run(2);
        set_duty(5, 3, 3, 3);
        load = 1'b1;
        step();
        set_duty(8, 3, 3, 3);
        step();
        load = 1'b0;
        chk("dbl_lp", 32'(load_pending), 32'd1);
        run(6);
        clr();
        run(10);
        chk("dbl_hi0", 32'(hi[0]), 32'd8);

        // Enable/polarity
        enable = 1'b0; polarity = 4'b1010;
        run(2);
        clr();
        run(10);
        chk("dis_pwm", 32'(pwm_out), 32'b1010);
        chk("dis_ticks", 32'(ticks), 32'd0);
        period_in = 4; set_duty(2, 2, 2, 2);
        do_load();
        chk("dis_load_lp", 32'(load_pending), 32'd0);
        enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!period_tick && n < 50);
        chk("first_tick_latency", 32'(n), 32'd5);

        // Async reset mid-period at cnt=5
        polarity = '0; period_in = 9; set_duty(9, 9, 9, 9);
        do_load();
        run(30);
        sync_tick();
        run(4);
        set_duty(1, 1, 1, 1);
        do_load();
        chk("pre_reset_pwm", 32'(pwm_out), 32'hf);
        #3 reset_p = 1'b1;
        model_reset();
        #1;
        chk("async_pwm", 32'(pwm_out), 32'd0);
        chk("async_tick", 32'(period_tick), 32'd0);
        chk("async_lp", 32'(load_pending), 32'd0);
        @(negedge clk);
        period_in = 0; set_duty(0, 0, 0, 0); enable = 1'b1; load = 1'b0;
        reset_p = 1'b0;
        clr();
        run(5);
        chk("p0_ticks", 32'(ticks), 32'd5);
        chk("p0_hi", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);

        // Random segments
        for (int s = 0; s < 40; s++) begin
            period_in = W'($urandom_range(0, 12));
            mode_in   = 1'($urandom_range(0, 1));
            for (int i = 0; i < CH; i++)
                duty_in[i*W +: W] = W'($urandom_range(0, int'(period_in) + 2));
            polarity = 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 7) != 0);
            load = 1'b1;
            step();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < CH; i++)
                    duty_in[i*W +: W] = W'($urandom_range(0, int'(period_in) + 2));
                step();
            end
            load = 1'b0;
            run($urandom_range(1, 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
